// File: rtl/alu_req_scheduler.sv
// Two-port round-robin front-end for the shared ALU: accept, drive ALU from registers, capture, respond.
// Optional: define ALU_SCHED_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module alu_req_scheduler #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [5:0]   req0_opcode,
  input  logic [5:0]   req0_ctrl,
  input  logic [4:0]   req0_shamt,
  input  logic [15:0]  req0_imm,
  input  logic [W-1:0] req0_rs,
  input  logic [W-1:0] req0_rt,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [5:0]   req1_opcode,
  input  logic [5:0]   req1_ctrl,
  input  logic [4:0]   req1_shamt,
  input  logic [15:0]  req1_imm,
  input  logic [W-1:0] req1_rs,
  input  logic [W-1:0] req1_rt,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_res,
  output logic         rsp_branch,
  output logic [5:0]   alu_opcode,
  output logic [5:0]   alu_ctrl,
  output logic [4:0]   alu_shamt,
  output logic [15:0]  alu_imm,
  output logic [W-1:0] alu_rs,
  output logic [W-1:0] alu_rt,
  input  logic [W-1:0] alu_res,
  input  logic         alu_branch,
  output logic         busy
);

  localparam int unsigned OwnerW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e              state_q;
  logic [OwnerW-1:0]   owner_q;
  logic [W-1:0]        rsp_res_q;
  logic                rsp_branch_q;
  logic [5:0]          alu_opcode_q;
  logic [5:0]          alu_ctrl_q;
  logic [4:0]          alu_shamt_q;
  logic [15:0]         alu_imm_q;
  logic [W-1:0]        alu_rs_q;
  logic [W-1:0]        alu_rt_q;
  logic                prio_c;
  logic                idle_c;
  logic                grant1_c;
  logic                rsp_hs_c;
  logic                is_branch_c;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  assign prio_c = 1'b0;
`else
  logic prio_q;
  assign prio_c = prio_q;
`endif

  // Port 1 wins when it is alone or when both are valid and it holds priority.
  assign idle_c      = (state_q == S_IDLE);
  assign grant1_c    = req1_valid && (!req0_valid || prio_c);
  assign req0_ready  = idle_c && req0_valid && !grant1_c;
  assign req1_ready  = idle_c && grant1_c;
  assign rsp_hs_c    = (owner_q == OwnerW'(1)) ? rsp1_ready : rsp0_ready;
  // Branch flag is only meaningful for beq/bne; otherwise the ALU output is stale.
  assign is_branch_c = (alu_opcode_q == 6'h04) || (alu_opcode_q == 6'h05);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      rsp_res_q    <= '0;
      rsp_branch_q <= 1'b0;
      alu_opcode_q <= '0;
      alu_ctrl_q   <= '0;
      alu_shamt_q  <= '0;
      alu_imm_q    <= '0;
      alu_rs_q     <= '0;
      alu_rt_q     <= '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      prio_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0_ready || req1_ready) begin
            alu_opcode_q <= grant1_c ? req1_opcode : req0_opcode;
            alu_ctrl_q   <= grant1_c ? req1_ctrl   : req0_ctrl;
            alu_shamt_q  <= grant1_c ? req1_shamt  : req0_shamt;
            alu_imm_q    <= grant1_c ? req1_imm    : req0_imm;
            alu_rs_q     <= grant1_c ? req1_rs     : req0_rs;
            alu_rt_q     <= grant1_c ? req1_rt     : req0_rt;
            owner_q      <= OwnerW'(grant1_c);
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_res_q    <= alu_res;
          rsp_branch_q <= is_branch_c ? alu_branch : 1'b0;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_hs_c) begin
            state_q <= S_IDLE;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            prio_q  <= ~owner_q[0];
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp0_valid = (state_q == S_RESP) && (owner_q == OwnerW'(0));
  assign rsp1_valid = (state_q == S_RESP) && (owner_q == OwnerW'(1));
  assign busy       = !idle_c;
  assign rsp_res    = rsp_res_q;
  assign rsp_branch = rsp_branch_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_shamt  = alu_shamt_q;
  assign alu_imm    = alu_imm_q;
  assign alu_rs     = alu_rs_q;
  assign alu_rt     = alu_rt_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Randomized bench for alu_req_scheduler against a transaction-level reference model.
module tb_alu_req_scheduler;

  localparam int unsigned W = 32;

  typedef struct {
    logic [5:0]   op;
    logic [5:0]   ctrl;
    logic [4:0]   sh;
    logic [15:0]  imm;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [5:0] req0_opcode = '0, req0_ctrl = '0, req1_opcode = '0, req1_ctrl = '0;
  logic [4:0] req0_shamt = '0, req1_shamt = '0;
  logic [15:0] req0_imm = '0, req1_imm = '0;
  logic [W-1:0] req0_rs = '0, req0_rt = '0, req1_rs = '0, req1_rt = '0;
  logic rsp0_valid, rsp1_valid;
  logic rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [W-1:0] rsp_res;
  logic rsp_branch;
  logic [5:0] alu_opcode, alu_ctrl;
  logic [4:0] alu_shamt;
  logic [15:0] alu_imm;
  logic [W-1:0] alu_rs, alu_rt, alu_res;
  logic alu_branch;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;
  int prio_m   = 0;

  always #5 clk = ~clk;

  alu_req_scheduler #(.NREQ(2), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_ctrl(req0_ctrl), .req0_shamt(req0_shamt), .req0_imm(req0_imm),
    .req0_rs(req0_rs), .req0_rt(req0_rt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_ctrl(req1_ctrl), .req1_shamt(req1_shamt), .req1_imm(req1_imm),
    .req1_rs(req1_rs), .req1_rt(req1_rt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_branch(rsp_branch),
    .alu_opcode(alu_opcode), .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt),
    .alu_imm(alu_imm), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_res(alu_res), .alu_branch(alu_branch), .busy(busy)
  );

  // Toy ALU: add for R-type add, else a mix; branch flag is stale-high for non-branch opcodes.
  function automatic logic [W-1:0] ref_res(op_t o);
    if (o.op == 6'h00 && o.ctrl == 6'h20) return o.rs + o.rt;
    return (o.rs ^ o.rt) + {16'h0, o.imm} + W'(o.sh);
  endfunction

  function automatic logic ref_br(op_t o);
    if (o.op == 6'h04) return o.rs == o.rt;
    if (o.op == 6'h05) return o.rs != o.rt;
    return 1'b1;
  endfunction

  always_comb begin
    op_t a;
    a.op = alu_opcode; a.ctrl = alu_ctrl; a.sh = alu_shamt;
    a.imm = alu_imm; a.rs = alu_rs; a.rt = alu_rt;
    alu_res    = ref_res(a);
    alu_branch = ref_br(a);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic v, input op_t o);
    if (p == 0) begin
      req0_valid = v; req0_opcode = o.op; req0_ctrl = o.ctrl; req0_shamt = o.sh;
      req0_imm = o.imm; req0_rs = o.rs; req0_rt = o.rt;
    end else begin
      req1_valid = v; req1_opcode = o.op; req1_ctrl = o.ctrl; req1_shamt = o.sh;
      req1_imm = o.imm; req1_rs = o.rs; req1_rt = o.rt;
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    logic [2:0] k;
    k = 3'($urandom_range(0, 4));
    case (k)
      3'd0: o.op = 6'h00;
      3'd1: o.op = 6'h04;
      3'd2: o.op = 6'h05;
      3'd3: o.op = 6'h08;
      default: o.op = 6'($urandom);
    endcase
    o.ctrl = ($urandom_range(0, 1) == 0) ? 6'h20 : 6'($urandom);
    o.sh = 5'($urandom); o.imm = 16'($urandom);
    o.rs = $urandom; o.rt = ($urandom_range(0, 2) == 0) ? o.rs : $urandom;
    return o;
  endfunction

  function automatic op_t mk(input logic [5:0] op, input logic [5:0] ctrl,
                             input logic [W-1:0] rs, input logic [W-1:0] rt);
    op_t o;
    o.op = op; o.ctrl = ctrl; o.sh = '0; o.imm = 16'h0003; o.rs = rs; o.rt = rt;
    return o;
  endfunction

  function automatic int winner(input logic v0, input logic v1);
    if (v0 && v1) return prio_m;
    return v1 ? 1 : 0;
  endfunction

  // One full transaction: arbitration, EXEC, RESP with optional backpressure, completion.
  task automatic run_op(input logic v0, input logic v1, input op_t o0, input op_t o1, input int hold);
    int w;
    op_t ow;
    logic [W-1:0] exp_res;
    logic exp_br;
    @(negedge clk);
    drive(0, v0, o0); drive(1, v1, o1);
    #1;
    w = winner(v0, v1);
    ow = (w == 1) ? o1 : o0;
    exp_res = ref_res(ow);
    exp_br = (ow.op == 6'h04 || ow.op == 6'h05) ? ref_br(ow) : 1'b0;
    check("req0_ready", W'(req0_ready), W'(v0 && w == 0));
    check("req1_ready", W'(req1_ready), W'(v1 && w == 1));
    @(negedge clk);
    check("exec_busy", W'(busy), W'(1));
    check("exec_rsp", W'({rsp1_valid, rsp0_valid}), W'(0));
    check("exec_alu_rs", alu_rs, ow.rs);
    check("exec_alu_op", W'({alu_opcode, alu_ctrl, alu_shamt, alu_imm}), W'({ow.op, ow.ctrl, ow.sh, ow.imm}));
    check("exec_alu_rt", alu_rt, ow.rt);
    if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (w == 0) req1_valid = 1'($urandom_range(0, 1)); else req0_valid = 1'($urandom_range(0, 1));
    #1;
    check("exec_ready", W'({req1_ready, req0_ready}), W'(0));
    @(negedge clk);
    check("rsp_valid", W'({rsp1_valid, rsp0_valid}), (w == 1) ? W'(2) : W'(1));
    check("rsp_res", rsp_res, exp_res);
    check("rsp_branch", W'(rsp_branch), W'(exp_br));
    for (int i = 0; i < hold; i++) begin
      if (w == 0) rsp1_ready = 1'($urandom_range(0, 1)); else rsp0_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_valid", W'({rsp1_valid, rsp0_valid}), (w == 1) ? W'(2) : W'(1));
      check("bp_res", rsp_res, exp_res);
      check("bp_alu_rs", alu_rs, ow.rs);
      check("bp_busy_ready", W'({busy, req1_ready, req0_ready}), W'(3'b100));
    end
    rsp0_ready = (w == 0); rsp1_ready = (w == 1);
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check("done_busy", W'(busy), W'(0));
    check("done_rsp", W'({rsp1_valid, rsp0_valid}), W'(0));
    check("done_alu_keep", alu_rs, ow.rs);
`ifndef ALU_SCHED_FIXED_PRIO_EN
    prio_m = 1 - w;
`endif
    drive(0, 1'b0, o0); drive(1, 1'b0, o1);
  endtask

  initial begin
    op_t a, b;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_rsp", W'({rsp1_valid, rsp0_valid, rsp_branch}), W'(0));
    check("rst_res", rsp_res, W'(0));
    check("rst_alu", W'({alu_opcode, alu_ctrl, alu_shamt, alu_imm}) | alu_rs | alu_rt, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", W'({req1_ready, req0_ready}), W'(0));

    // Single add request on port 0: 5 + 7 = 12.
    a = mk(6'h00, 6'h20, 32'd5, 32'd7);
    run_op(1'b1, 1'b0, a, a, 0);
    check("add_res", rsp_res, W'(12));
    // Branch masking on port 1.
    b = mk(6'h04, 6'h00, 32'd9, 32'd9);
    run_op(1'b0, 1'b1, b, b, 0);
    check("beq_taken", W'(rsp_branch), W'(1));
    b = mk(6'h08, 6'h00, 32'd1, 32'd2);
    run_op(1'b0, 1'b1, b, b, 1);
    check("addi_masked", W'(rsp_branch), W'(0));
    // Contention with both ports valid.
    for (int i = 0; i < 4; i++) run_op(1'b1, 1'b1, rand_op(), rand_op(), 0);
    // Backpressure for 5 cycles.
    run_op(1'b1, 1'b0, rand_op(), rand_op(), 5);
    // Randomized traffic with occasional idle cycles.
    for (int i = 0; i < 60; i++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) begin
        @(negedge clk);
        #1;
        check("idle_noreq", W'({busy, req1_ready, req0_ready}), W'(0));
      end else begin
        run_op(v0, v1, rand_op(), rand_op(), $urandom_range(0, 3));
      end
    end

    // Reset during EXEC after port 0 takes priority away from itself.
    run_op(1'b1, 1'b0, rand_op(), rand_op(), 0);
    @(negedge clk);
    drive(0, 1'b1, rand_op()); drive(1, 1'b1, rand_op());
    @(negedge clk);
    check("pre_rst_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_alu", W'({alu_opcode, alu_ctrl, alu_shamt, alu_imm}) | alu_rs | alu_rt, W'(0));
    check("mid_rst_out", W'({rsp1_valid, rsp0_valid, rsp_branch, req1_ready, req0_ready}) | rsp_res, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    prio_m = 0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rsp", W'({busy, rsp1_valid, rsp0_valid}), W'(0));
    end
    run_op(1'b1, 1'b1, rand_op(), rand_op(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
